// File: rtl/apb_pkg.sv
// Shared APB definitions used by the master and slave sides of the link.
//   apb_state_t : bus phase of a transfer (IDLE, SETUP, ACCESS)
//   apb_req_t   : one registered command (direction, slave id, address, write data)
//   apb_sel()   : slave id to one-hot PSEL decode
// The command struct carries the widest legal APB fields (32-bit address and data), so
// any configured ADDR_W/DATA_W up to 32 fits without a per-instance type.
package apb_pkg;

  localparam int unsigned APB_ADDR_W     = 8;
  localparam int unsigned APB_DATA_W     = 32;
  localparam int unsigned APB_MAX_W      = 32;
  localparam int unsigned APB_MAX_SLAVES = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  typedef struct packed {
    logic                 write;
    logic [1:0]           id;
    logic [APB_MAX_W-1:0] addr;
    logic [APB_MAX_W-1:0] wdata;
  } apb_req_t;

  function automatic logic [APB_MAX_SLAVES-1:0] apb_sel(input logic [1:0] id);
    return APB_MAX_SLAVES'(1) << id;
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Clear/enable wait-state counter with a terminal-count flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear_i    : synchronous clear (priority over enable)
//   enable_i   : count this cycle
//   expired_o  : this enabled cycle brings the count to TIMEOUT
module apb_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != CntW'(TIMEOUT))) begin
      count_d = count_q + CntW'(1);
    end
  end

  // Flag the cycle that would be the TIMEOUT-th counted one, so the owner can leave
  // in that same cycle rather than one later.
  assign expired_o = enable_i && (count_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/apb_master.sv
// APB initiator: takes single read/write commands from a local requester and runs the
// SETUP/ACCESS sequence towards one of up to four slaves.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : command handshake; req_write/req_id/req_addr/req_wdata payload
//   rsp_valid           : one-cycle completion pulse; rsp_rdata/rsp_err hold until the next
//   psel/penable/pwrite/paddr/pwdata : APB request outputs (all 0 while idle)
//   prdata/pready/pslverr            : APB response inputs, only looked at in ACCESS
// ADDR_W and DATA_W must not exceed 32; NUM_SLAVES must be 1..4; TIMEOUT must be >= 1.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W     = APB_ADDR_W,
  parameter int unsigned DATA_W     = APB_DATA_W,
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_id,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [3:0]        psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_state_t        state_q, state_d;
  apb_req_t          req_q, req_d;
  logic              rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic              rsp_err_d;
  logic              timer_clear, timer_en, timer_expired;
  logic              bad_id;
  logic [3:0]        sel;
  logic              unused_req;

  assign bad_id = 32'(req_id) >= NUM_SLAVES;
  assign sel    = apb_sel(req_q.id);

  // Struct fields above ADDR_W/DATA_W are stored as zero and never reach the bus.
  assign unused_req = ^{req_q.addr, req_q.wdata};

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (timer_clear),
    .enable_i  (timer_en),
    .expired_o (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    req_ready   = 1'b0;
    psel        = '0;
    penable     = 1'b0;
    pwrite      = 1'b0;
    paddr       = '0;
    pwdata      = '0;
    timer_clear = 1'b1;
    timer_en    = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          req_d = '{write: req_write,
                    id:    req_id,
                    addr:  APB_MAX_W'(req_addr),
                    wdata: APB_MAX_W'(req_wdata)};
          if (bad_id) begin
            // Unpopulated slave: answer with an error without touching the bus.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d = SETUP;
          end
        end
      end

      SETUP: begin
        psel    = sel;
        pwrite  = req_q.write;
        paddr   = req_q.addr[ADDR_W-1:0];
        pwdata  = req_q.wdata[DATA_W-1:0];
        state_d = ACCESS;
      end

      ACCESS: begin
        psel        = sel;
        penable     = 1'b1;
        pwrite      = req_q.write;
        paddr       = req_q.addr[ADDR_W-1:0];
        pwdata      = req_q.wdata[DATA_W-1:0];
        timer_clear = 1'b0;
        timer_en    = !pready;
        if (pready) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr;
          rsp_rdata_d = (!req_q.write && !pslverr) ? prdata : '0;
          state_d     = IDLE;
        end else if (timer_expired) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: a memory-backed slave with programmable wait states,
// stuck-low PREADY and PSLVERR, plus a second instance with two populated slaves.
module tb_apb_master;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main instance: four slaves, TIMEOUT 16
  logic        req_valid, req_ready, req_write;
  logic [1:0]  req_id;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [3:0]  psel;
  logic        penable, pwrite, pready, pslverr;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata;

  // Second instance: two slaves populated
  logic        b_req_valid, b_req_ready, b_req_write;
  logic [1:0]  b_req_id;
  logic [7:0]  b_req_addr;
  logic [31:0] b_req_wdata;
  logic        b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;
  logic [3:0]  b_psel;
  logic        b_penable, b_pwrite;
  logic [7:0]  b_paddr;
  logic [31:0] b_pwdata;
  logic [31:0] b_prdata  = 32'h1111_1111;
  logic        b_pready  = 1'b1;
  logic        b_pslverr = 1'b0;

  apb_master #(.ADDR_W(8), .DATA_W(32), .NUM_SLAVES(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_id(req_id),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  apb_master #(.ADDR_W(8), .DATA_W(32), .NUM_SLAVES(2), .TIMEOUT(16)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_id(b_req_id), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .psel(b_psel), .penable(b_penable), .pwrite(b_pwrite), .paddr(b_paddr),
    .pwdata(b_pwdata), .prdata(b_prdata), .pready(b_pready), .pslverr(b_pslverr)
  );

  // Slave model: memory indexed by {slave id, address}
  int unsigned wait_cfg  = 0;
  logic        stuck_cfg = 1'b0;
  logic        err_cfg   = 1'b0;
  int unsigned acc_cnt   = 0;
  logic [31:0] mem [0:1023];
  logic [1:0]  sel_id;

  always_comb begin
    sel_id = 2'd0;
    for (int i = 0; i < 4; i++) if (psel[i]) sel_id = 2'(i);
  end

  assign pready  = penable && !stuck_cfg && (acc_cnt >= wait_cfg);
  assign pslverr = pready && err_cfg;
  assign prdata  = mem[{sel_id, paddr}];

  always @(posedge clk) begin
    if (penable && !pready) acc_cnt <= acc_cnt + 1;
    else                    acc_cnt <= 0;
    if (pready && pwrite && !err_cfg) mem[{sel_id, paddr}] <= pwdata;
  end

  // Scoreboard
  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_and_check(input string tag, input logic [31:0] rdata, input logic err);
    exp_t e;
    if (exp_q.size() == 0) begin
      check($sformatf("%s scoreboard empty", tag), 64'(exp_q.size()), 64'd1);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("%s rdata", tag), 64'(rdata), 64'(e.rdata));
      check($sformatf("%s err", tag), 64'(err), 64'(e.err));
    end
  endtask

  // One command on the main instance. exp_lat counts cycles from handshake to rsp_valid.
  task automatic run_req(input string tag, input logic wr, input logic [1:0] id,
                         input logic [7:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_lat, input int exp_acc, input logic [3:0] exp_psel);
    int          lat, setup_n, acc_n;
    logic        stable;
    logic [3:0]  psel_seen;
    logic [31:0] held_rdata;
    logic        held_err;
    exp_t        e;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    exp_q.push_back(e);
    @(negedge clk);
    check($sformatf("%s req_ready", tag), 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = wr; req_id = id; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0; req_addr = 8'hFF; req_wdata = 32'hFFFF_FFFF; req_write = ~wr;
    lat = 0; setup_n = 0; acc_n = 0; stable = 1'b1; psel_seen = 4'd0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
      psel_seen |= psel;
      if (psel != 4'd0 && !penable) setup_n++;
      if (penable) begin
        acc_n++;
        if (paddr !== addr || pwrite !== wr || (wr && pwdata !== wdata)) stable = 1'b0;
      end
    end
    check($sformatf("%s rsp_valid", tag), 64'(rsp_valid), 64'd1);
    check($sformatf("%s latency", tag), 64'(lat), 64'(exp_lat));
    pop_and_check(tag, rsp_rdata, rsp_err);
    check($sformatf("%s setup cycles", tag), 64'(setup_n), 64'(exp_psel != 4'd0));
    check($sformatf("%s access cycles", tag), 64'(acc_n), 64'(exp_acc));
    check($sformatf("%s psel", tag), 64'(psel_seen), 64'(exp_psel));
    check($sformatf("%s bus stable", tag), 64'(stable), 64'd1);
    check($sformatf("%s bus idle at rsp", tag), 64'({psel, penable}), 64'd0);
    check($sformatf("%s ready at rsp", tag), 64'(req_ready), 64'd1);
    held_rdata = rsp_rdata;
    held_err   = rsp_err;
    @(negedge clk);
    check($sformatf("%s rsp pulse", tag), 64'(rsp_valid), 64'd0);
    check($sformatf("%s rsp hold", tag), 64'({held_err, held_rdata}),
          64'({exp_err, exp_rdata}));
    check($sformatf("%s rsp hold now", tag), 64'({rsp_err, rsp_rdata}),
          64'({exp_err, exp_rdata}));
  endtask

  initial begin
    int   seen;
    exp_t e;
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_id = 2'd0; req_addr = 8'h00; req_wdata = '0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_id = 2'd0; b_req_addr = 8'h40;
    b_req_wdata = '0;
    repeat (2) @(negedge clk);
    check("reset req_ready", 64'(req_ready), 64'd1);
    check("reset rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);
    check("reset psel", 64'(psel), 64'd0);
    check("reset penable", 64'(penable), 64'd0);
    check("reset pwrite", 64'(pwrite), 64'd0);
    check("reset paddr", 64'(paddr), 64'd0);
    check("reset pwdata", 64'(pwdata), 64'd0);
    check("reset b rsp", 64'({b_rsp_valid, b_rsp_err, b_rsp_rdata}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Unpopulated slave id on the two-slave instance
    e.rdata = 32'd0; e.err = 1'b1;
    exp_q.push_back(e);
    b_req_valid = 1'b1; b_req_id = 2'd3; b_req_write = 1'b0;
    @(posedge clk);
    #1 b_req_valid = 1'b0;
    @(negedge clk);
    check("badid rsp_valid", 64'(b_rsp_valid), 64'd1);
    pop_and_check("badid", b_rsp_rdata, b_rsp_err);
    check("badid psel", 64'({b_psel, b_penable}), 64'd0);
    check("badid ready", 64'(b_req_ready), 64'd1);
    @(negedge clk);
    check("badid pulse", 64'(b_rsp_valid), 64'd0);

    // Zero-wait write then read back
    run_req("wr1", 1'b1, 2'd1, 8'h10, 32'hDEAD_BEEF, 32'd0, 1'b0, 3, 1, 4'b0010);
    run_req("rd1", 1'b0, 2'd1, 8'h10, 32'd0, 32'hDEAD_BEEF, 1'b0, 3, 1, 4'b0010);
    // Write over live data: prdata is non-zero but must not be returned
    run_req("wr2", 1'b1, 2'd1, 8'h10, 32'h1234_5678, 32'd0, 1'b0, 3, 1, 4'b0010);
    run_req("wr3", 1'b1, 2'd2, 8'h20, 32'hA5A5_0F0F, 32'd0, 1'b0, 3, 1, 4'b0100);
    run_req("wr4", 1'b1, 2'd0, 8'h01, 32'h0BAD_F00D, 32'd0, 1'b0, 3, 1, 4'b0001);

    // Three wait states
    wait_cfg = 3;
    run_req("rdwait", 1'b0, 2'd2, 8'h20, 32'd0, 32'hA5A5_0F0F, 1'b0, 6, 4, 4'b0100);

    // Stuck slave: timeout after exactly 16 ACCESS cycles
    stuck_cfg = 1'b1;
    run_req("timeout", 1'b0, 2'd3, 8'h30, 32'd0, 32'd0, 1'b1, 18, 16, 4'b1000);
    stuck_cfg = 1'b0;

    // Ready in the last permitted ACCESS cycle is a success
    wait_cfg = 15;
    run_req("lastok", 1'b0, 2'd0, 8'h01, 32'd0, 32'h0BAD_F00D, 1'b0, 18, 16, 4'b0001);
    wait_cfg = 0;

    // Slave error on a read
    err_cfg = 1'b1;
    run_req("slverr", 1'b0, 2'd2, 8'h20, 32'd0, 32'd0, 1'b1, 3, 1, 4'b0100);
    err_cfg = 1'b0;

    // Reset during ACCESS
    stuck_cfg = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_id = 2'd0; req_addr = 8'h33;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("abort in access", 64'({psel, penable}), 64'({4'b0001, 1'b1}));
    #2 rst_n = 1'b0;
    #1;
    check("abort psel", 64'(psel), 64'd0);
    check("abort penable", 64'(penable), 64'd0);
    check("abort paddr", 64'(paddr), 64'd0);
    check("abort rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stuck_cfg = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("abort no rsp", 64'(seen), 64'd0);
    run_req("post_rst", 1'b0, 2'd1, 8'h10, 32'd0, 32'h1234_5678, 1'b0, 3, 1, 4'b0010);

    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/apb_master.md
# apb_master

- Initiator end of the APB link.
- Accepts single read/write commands from a local requester (test sequencer, I2C bridge or CPU-side logic).
- Runs the two-phase APB SETUP/ACCESS protocol towards up to four slaves selected by a 2-bit id, honours PREADY wait states, and returns read data and error status.
- A watchdog counter terminates transfers whose slave never asserts PREADY.

## Interface
Parameters:
- ADDR_W, 8, APB address width
- DATA_W, 32, APB data width
- NUM_SLAVES, 4, slaves actually populated; legal ids 0..NUM_SLAVES-1 (max 4)
- TIMEOUT, 16, max ACCESS cycles waiting for PREADY (≥1)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  command present
- req_ready  out  1  command accepted when req_valid & req_ready
- req_write  in  1  1 = write, 0 = read
- req_id  in  2  target slave id
- req_addr  in  ADDR_W  transfer address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data (0 for writes/errors)
- rsp_err  out  1  PSLVERR, timeout or bad id
- psel  out  4  one-hot slave select, bit = id
- penable  out  1  ACCESS phase
- pwrite  out  1  direction
- paddr  out  ADDR_W  address
- pwdata  out  DATA_W  write data
- prdata  in  DATA_W  read data of selected slave (muxed externally)
- pready  in  1  slave ready
- pslverr  in  1  slave error

## Operation
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - req_ready=1, all APB outputs 0.
  - On handshake, register write/id/addr/wdata.
  - If id ≥ NUM_SLAVES: no bus activity; next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0; stay IDLE.
  - Otherwise go to SETUP.
- SETUP:
  - psel[id]=1, penable=0; paddr, pwrite, pwdata driven from registers.
  - Always go to ACCESS next cycle.
- ACCESS:
  - psel[id]=1, penable=1; paddr/pwrite/pwdata held stable.
  - Wait counter increments each ACCESS cycle that pready=0.
  - pready=1: capture pslverr; capture prdata on reads only (rsp_rdata=0 on writes or pslverr=1). Go to IDLE.
  - Counter reaches TIMEOUT with pready=0: abandon the transfer (psel/penable drop), rsp_err=1, rsp_rdata=0, go to IDLE.
- Completion: rsp_valid pulses for exactly one cycle, in the first IDLE cycle after the transfer. No backpressure on the response. rsp_rdata/rsp_err hold until the next completion.
- pready/pslverr/prdata are ignored outside ACCESS.
- req_* inputs are ignored while req_ready=0.

## Timing
- Reset (async assert, sync release): state IDLE; req_ready=1; rsp_valid=0, rsp_rdata=0, rsp_err=0; psel=0, penable=0, pwrite=0, paddr=0, pwdata=0; counter 0.
- Zero-wait transfer:
  - handshake at cycle N
  - SETUP at N+1
  - ACCESS at N+2 with pready=1
  - rsp_valid and req_ready at N+3
- Back-to-back: a new handshake in cycle N+3 gives SETUP at N+4, so there is one idle bus cycle between transfers.
- Each wait state adds one cycle.
- Timeout transfer: ACCESS lasts exactly TIMEOUT cycles; rsp_valid arrives on the next cycle.
- pready=1 in the final permitted ACCESS cycle counts as success, not timeout.
- Reset asserted mid-transfer: psel/penable drop immediately; no rsp_valid is issued for the aborted command.

## Structure
- apb_pkg (shared with the slave side): state enum apb_state_t {IDLE, SETUP, ACCESS}, default ADDR_W/DATA_W, and a request struct apb_req_t {write, id, addr, wdata}.
- One natural sub-module, apb_wait_timer: clear/enable counter with a `expired` output at TIMEOUT. Reusable by the I2C bridge.
- The top level adapts to the APB_Bus interface master modport in the bench wrapper.

## Test plan
- Write id=1, addr=0x10, data=0xDEADBEEF, slave pready tied 1 → psel=4'b0010 for 2 cycles, penable only in the 2nd; rsp_valid 3 cycles after handshake, rsp_err=0.
- Read id=1, addr=0x10 from a memory-backed slave after the write above → rsp_rdata=0xDEADBEEF, rsp_err=0.
- Read id=2 with pready held low 3 cycles → ACCESS lasts 4 cycles; paddr/pwrite stable throughout; rsp_valid 6 cycles after handshake.
- Read id=3 with pready stuck 0, TIMEOUT=16 → exactly 16 ACCESS cycles, then rsp_err=1, rsp_rdata=0, psel=0.
- NUM_SLAVES=2, request id=3 → psel stays 0; rsp_valid next cycle with rsp_err=1. Separately, slave returns pslverr=1 on a read → rsp_err=1, rsp_rdata=0.
- Reset pulsed during ACCESS → all outputs 0 immediately, no rsp_valid; the next request completes normally.
